// File: rtl/filters_serial_fir.sv
// rtl/filters_serial_fir.sv - time-multiplexed single-multiplier FIR filter
module filters_serial_fir #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 16,
    parameter int TAPS   = 32,
    parameter int AWIDTH = 9,
    parameter int OWIDTH = DWIDTH + CWIDTH + $clog2(TAPS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DWIDTH-1:0] sample_i,
    input  logic              sample_valid_i,
    output logic              sample_ready_o,
    output logic [AWIDTH-1:0] coef_addr_o,
    input  logic [CWIDTH-1:0] coef_i,
    output logic [OWIDTH-1:0] result_o,
    output logic              result_valid_o
);

    localparam int IW = $clog2(TAPS);
    localparam int PW = DWIDTH + CWIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [IW-1:0]            cnt_q, cnt_d;
    logic [IW-1:0]            idx_q;
    logic                     vld_q;
    logic                     ready_q, ready_d;
    logic signed [DWIDTH-1:0] x_q [TAPS];
    logic signed [OWIDTH-1:0] acc_q;
    logic signed [OWIDTH-1:0] result_q;
    logic                     result_valid_q;

    logic                     accept;
    logic signed [PW-1:0]     prod;
    logic signed [OWIDTH-1:0] prod_ext;
    logic signed [OWIDTH-1:0] sum;

    // ready is only ever high in IDLE, so a handshake implies IDLE
    assign accept = sample_valid_i && ready_q;

    // both operands widened to the full product width before multiplying
    assign prod     = PW'($signed(coef_i)) * PW'(x_q[idx_q]);
    assign prod_ext = OWIDTH'(prod);
    assign sum      = acc_q + prod_ext;

    assign sample_ready_o = ready_q;
    assign coef_addr_o    = (state_q == RUN) ? AWIDTH'(cnt_q) : '0;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;

    // FSM state, tap counter and ready register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // next-state: IDLE waits for a sample, RUN walks the ROM, DRAIN catches the last tap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                cnt_d   = '0;
                if (accept) begin
                    state_d = RUN;
                    ready_d = 1'b0;
                end
            end
            RUN: begin
                ready_d = 1'b0;
                if (cnt_q == IW'(TAPS - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // delay line, accumulator and result; ROM data lags the address by one cycle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
            acc_q          <= '0;
            idx_q          <= '0;
            vld_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            idx_q          <= cnt_q;
            vld_q          <= (state_q == RUN);
            result_valid_q <= 1'b0;
            if (accept) begin
                for (int k = TAPS - 1; k > 0; k--) begin
                    x_q[k] <= x_q[k-1];
                end
                x_q[0] <= $signed(sample_i);
                acc_q  <= '0;
            end
            if (vld_q) begin
                if (state_q == DRAIN) begin
                    result_q       <= sum;
                    result_valid_q <= 1'b1;
                    acc_q          <= '0;
                end else begin
                    acc_q <= sum;
                end
            end
        end
    end

endmodule
